// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier among NUM_REQ requesters.
// Tags each issued operation with its requester and routes products back in order.
module complex_mult_arbiter #(
   parameter int WIDTH        = 16,
   parameter int NUM_REQ      = 4,
   parameter int MULT_LATENCY = 6,
   parameter int TAG_DEPTH    = 8,
   localparam int CNT_W       = $clog2(TAG_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_ar,
   input  logic [NUM_REQ*WIDTH-1:0]   req_ai,
   input  logic [NUM_REQ*WIDTH-1:0]   req_br,
   input  logic [NUM_REQ*WIDTH-1:0]   req_bi,
   output logic                       m_ab_valid,
   output logic [WIDTH-1:0]           m_ar,
   output logic [WIDTH-1:0]           m_ai,
   output logic [WIDTH-1:0]           m_br,
   output logic [WIDTH-1:0]           m_bi,
   input  logic                       m_p_valid,
   input  logic [2*WIDTH:0]           m_pr,
   input  logic [2*WIDTH:0]           m_pi,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [2*WIDTH:0]           rsp_pr,
   output logic [2*WIDTH:0]           rsp_pi,
   output logic [CNT_W-1:0]           inflight,
   output logic                       err_orphan
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int FCNT_W = $clog2(MULT_LATENCY + 1);

   typedef enum logic {ST_FLUSH, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic [FCNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
   logic [IDX_W-1:0]    last_reg;
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]    inflight_reg;
   logic                m_ab_valid_reg;
   logic [WIDTH-1:0]    m_ar_reg, m_ai_reg, m_br_reg, m_bi_reg;
   logic [NUM_REQ-1:0]  rsp_valid_reg;
   logic [2*WIDTH:0]    rsp_pr_reg, rsp_pi_reg;
   logic                err_orphan_reg;

   logic [IDX_W-1:0]    tag_mem [TAG_DEPTH];
   logic [IDX_W-1:0]    head_tag;

   logic [WIDTH-1:0]    ar_arr [NUM_REQ];
   logic [WIDTH-1:0]    ai_arr [NUM_REQ];
   logic [WIDTH-1:0]    br_arr [NUM_REQ];
   logic [WIDTH-1:0]    bi_arr [NUM_REQ];

   logic                grant_found;
   logic [IDX_W-1:0]    grant_idx;
   logic                can_grant;
   logic                push;
   logic                pop;
   logic                orphan;
   int                  cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign ar_arr[gi] = req_ar[gi*WIDTH +: WIDTH];
         assign ai_arr[gi] = req_ai[gi*WIDTH +: WIDTH];
         assign br_arr[gi] = req_br[gi*WIDTH +: WIDTH];
         assign bi_arr[gi] = req_bi[gi*WIDTH +: WIDTH];
      end
   endgenerate

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      case (state_reg)
         ST_FLUSH: begin
            if (flush_cnt_reg == FCNT_W'(MULT_LATENCY))
               state_next = ST_RUN;
            else
               flush_cnt_next = flush_cnt_reg + FCNT_W'(1);
         end
         default: state_next = ST_RUN;
      endcase
   end

   // Search starts one past the last grant and wraps, so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_reg;
      cand        = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_reg) + i;
         if (cand >= NUM_REQ)
            cand = cand - NUM_REQ;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   // Full FIFO blocks grants even if a pop lands this cycle; no bypass path.
   assign can_grant = (state_reg == ST_RUN) && (inflight_reg < CNT_W'(TAG_DEPTH));
   assign push      = can_grant && grant_found;
   assign req_ready = push ? (NUM_REQ'(1) << grant_idx) : '0;
   assign pop       = (state_reg == ST_RUN) && m_p_valid && (inflight_reg != '0);
   assign orphan    = (state_reg == ST_RUN) && m_p_valid && (inflight_reg == '0);
   assign head_tag  = tag_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push)
         tag_mem[wr_ptr_reg] <= grant_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_FLUSH;
         flush_cnt_reg  <= '0;
         last_reg       <= IDX_W'(NUM_REQ - 1);
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         inflight_reg   <= '0;
         m_ab_valid_reg <= 1'b0;
         m_ar_reg       <= '0;
         m_ai_reg       <= '0;
         m_br_reg       <= '0;
         m_bi_reg       <= '0;
         rsp_valid_reg  <= '0;
         rsp_pr_reg     <= '0;
         rsp_pi_reg     <= '0;
         err_orphan_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         flush_cnt_reg  <= flush_cnt_next;
         m_ab_valid_reg <= push;
         if (push) begin
            last_reg   <= grant_idx;
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            m_ar_reg   <= ar_arr[grant_idx];
            m_ai_reg   <= ai_arr[grant_idx];
            m_br_reg   <= br_arr[grant_idx];
            m_bi_reg   <= bi_arr[grant_idx];
         end
         if (pop) begin
            rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
            rsp_valid_reg <= NUM_REQ'(1) << head_tag;
            rsp_pr_reg    <= m_pr;
            rsp_pi_reg    <= m_pi;
         end else begin
            rsp_valid_reg <= '0;
         end
         case ({push, pop})
            2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
            2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
            default: inflight_reg <= inflight_reg;
         endcase
         if (orphan)
            err_orphan_reg <= 1'b1;
      end
   end

   assign m_ab_valid = m_ab_valid_reg;
   assign m_ar       = m_ar_reg;
   assign m_ai       = m_ai_reg;
   assign m_br       = m_br_reg;
   assign m_bi       = m_bi_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_pr     = rsp_pr_reg;
   assign rsp_pi     = rsp_pi_reg;
   assign inflight   = inflight_reg;
   assign err_orphan = err_orphan_reg;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Bench for complex_mult_arbiter: directed vector table plus multi-cycle sequences,
// with a behavioural multiplier of adjustable latency driving the return path.
module tb_complex_mult_arbiter;
   localparam int W   = 16;
   localparam int N   = 4;
   localparam int LAT = 6;
   localparam int TD  = 8;
   localparam int PW  = 2*W + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_ar, req_ai, req_br, req_bi;
   logic            m_ab_valid;
   logic [W-1:0]    m_ar, m_ai, m_br, m_bi;
   logic            m_p_valid = 1'b0;
   logic [PW-1:0]   m_pr = '0, m_pi = '0;
   logic [N-1:0]    rsp_valid;
   logic [PW-1:0]   rsp_pr, rsp_pi;
   logic [3:0]      inflight;
   logic            err_orphan;

   complex_mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .MULT_LATENCY(LAT), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
      .m_ab_valid(m_ab_valid), .m_ar(m_ar), .m_ai(m_ai), .m_br(m_br), .m_bi(m_bi),
      .m_p_valid(m_p_valid), .m_pr(m_pr), .m_pi(m_pi),
      .rsp_valid(rsp_valid), .rsp_pr(rsp_pr), .rsp_pi(rsp_pi),
      .inflight(inflight), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural multiplier: ring of result slots indexed by cycle number.
   logic                 slot_v  [64];
   logic [PW-1:0]        slot_pr [64];
   logic [PW-1:0]        slot_pi [64];
   int                   mcyc = 0;
   int                   mlat = LAT;
   logic                 inject = 1'b0;
   int                   ms, ms2;
   logic signed [PW-1:0] xar, xai, xbr, xbi;

   initial for (int i = 0; i < 64; i++) slot_v[i] = 1'b0;

   always @(negedge clk) begin
      ms = mcyc % 64;
      m_p_valid = slot_v[ms] | inject;
      if (slot_v[ms]) begin
         m_pr = slot_pr[ms];
         m_pi = slot_pi[ms];
      end
      slot_v[ms] = 1'b0;
      if (m_ab_valid === 1'b1) begin
         xar = $signed(m_ar); xai = $signed(m_ai);
         xbr = $signed(m_br); xbi = $signed(m_bi);
         ms2 = (mcyc + mlat) % 64;
         slot_v[ms2]  = 1'b1;
         slot_pr[ms2] = xar*xbr - xai*xbi;
         slot_pi[ms2] = xar*xbi + xai*xbr;
      end
      mcyc++;
   end

   // Scoreboard: responses must come back to requesters in grant order.
   int sb[$];
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         sb.delete();
      end else begin
         if (rsp_valid != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL rsp_order: got rsp_valid %b expected none at %0t", rsp_valid, $time);
            end else begin
               if (rsp_valid !== (N'(1) << sb[0])) begin
                  n_bad++;
                  $display("FAIL rsp_order: got rsp_valid %b expected requester %0d at %0t",
                           rsp_valid, sb[0], $time);
               end
               void'(sb.pop_front());
            end
         end
         for (int k = 0; k < N; k++)
            if (req_valid[k] && req_ready[k]) sb.push_back(k);
      end
   end

   typedef struct {
      int          k;
      logic [W-1:0]  ar, ai, br, bi;
      logic [PW-1:0] pr, pi;
   } vec_t;

   vec_t tbl [6];

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (inflight != 0 && t < 60) begin
         cyc();
         t++;
      end
      chk("drain_inflight", 64'(inflight), 64'd0);
      repeat (3) cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, dly, rr;
      logic found;

      tbl[0] = '{1, 16'd3,    16'd2,    16'd1,    16'd4,    -33'sd5,          33'sd14};
      tbl[1] = '{0, 16'hffff, 16'h0000, 16'hffff, 16'h0000, 33'sd1,           33'sd0};
      tbl[2] = '{2, 16'h7fff, 16'h7fff, 16'h7fff, 16'h8000, 33'sd2147385345,  -33'sd32767};
      tbl[3] = '{3, 16'h8000, 16'h8000, 16'h8000, 16'h7fff, 33'sd2147450880,  33'sd32768};
      tbl[4] = '{0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 33'sd0,           33'sd2147483648};
      tbl[5] = '{2, 16'h0007, 16'hfffb, 16'hfffd, 16'h0006, 33'sd9,           33'sd57};

      rst = 1'b1; req_valid = '0;
      req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_ab_valid", 64'(m_ab_valid), 64'd0);
      chk("rst_m_ar", 64'(m_ar), 64'd0);
      chk("rst_m_bi", 64'(m_bi), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_pr", 64'(rsp_pr), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_err", 64'(err_orphan), 64'd0);

      // Flush: 7 cycles of no ready with products injected, then requester 0 granted.
      cyc();
      rst = 1'b0; req_valid = 4'b0001; inject = 1'b1;
      req_ar = {4{16'd2}}; req_ai = {4{16'd1}}; req_br = {4{16'd3}}; req_bi = {4{16'd5}};
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("flush_ready", 64'(req_ready), 64'd0);
         chk("flush_rsp", 64'(rsp_valid), 64'd0);
         chk("flush_err", 64'(err_orphan), 64'd0);
         cyc();
      end
      inject = 1'b0;
      @(negedge clk);
      chk("flush_end_ready", 64'(req_ready), 64'b0001);
      chk("flush_end_rsp", 64'(rsp_valid), 64'd0);
      chk("flush_end_err", 64'(err_orphan), 64'd0);
      cyc();
      req_valid = '0;
      drain();

      for (int v = 0; v < 6; v++) begin
         k = tbl[v].k;
         req_ar = {4{16'h5a5a}}; req_ai = {4{16'h5a5a}};
         req_br = {4{16'ha5a5}}; req_bi = {4{16'ha5a5}};
         req_ar[k*W +: W] = tbl[v].ar; req_ai[k*W +: W] = tbl[v].ai;
         req_br[k*W +: W] = tbl[v].br; req_bi[k*W +: W] = tbl[v].bi;
         req_valid = N'(1) << k;
         @(negedge clk);
         chk("vec_ready", 64'(req_ready), 64'(N'(1) << k));
         cyc();
         req_valid = '0;
         @(negedge clk);
         chk("vec_ab_valid", 64'(m_ab_valid), 64'd1);
         chk("vec_m_ar", 64'(m_ar), 64'(tbl[v].ar));
         chk("vec_m_ai", 64'(m_ai), 64'(tbl[v].ai));
         chk("vec_m_br", 64'(m_br), 64'(tbl[v].br));
         chk("vec_m_bi", 64'(m_bi), 64'(tbl[v].bi));
         cyc();
         @(negedge clk);
         chk("vec_ab_idle", 64'(m_ab_valid), 64'd0);
         chk("vec_m_ar_hold", 64'(m_ar), 64'(tbl[v].ar));
         dly = 2; found = 1'b0;
         while (!found && dly < 20) begin
            cyc();
            dly++;
            @(negedge clk);
            if (rsp_valid != '0) found = 1'b1;
         end
         chk("vec_latency", 64'(dly), 64'(LAT + 2));
         chk("vec_rsp_valid", 64'(rsp_valid), 64'(N'(1) << k));
         chk("vec_rsp_pr", 64'(rsp_pr), 64'(tbl[v].pr));
         chk("vec_rsp_pi", 64'(rsp_pi), 64'(tbl[v].pi));
         $display("vector %0d: req %0d pr=0x%0h pi=0x%0h latency %0d", v, k, rsp_pr, rsp_pi, dly);
         cyc();
      end
      drain();

      // Round-robin with all requesters valid; search resumes after the last grant.
      rr = (tbl[5].k + 1) % N;
      req_valid = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(N'(1) << rr));
         rr = (rr + 1) % N;
         cyc();
      end
      req_valid = '0;
      drain();
      chk("rr_all_returned", 64'(sb.size()), 64'd0);

      // Credit stall with a slow multiplier: 8 grants, stall, resume after the pop cycle.
      mlat = 20;
      req_valid = 4'b0001;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk("credit_ready", 64'(req_ready), ((c < 8) || (c >= 22)) ? 64'd1 : 64'd0);
         if (c == 8) chk("credit_full", 64'(inflight), 64'(TD));
         cyc();
      end
      req_valid = '0;
      drain();
      chk("credit_all_returned", 64'(sb.size()), 64'd0);
      mlat = LAT;

      // Orphan product while idle.
      inject = 1'b1;
      @(negedge clk);
      chk("orphan_pre", 64'(err_orphan), 64'd0);
      cyc();
      inject = 1'b0;
      @(negedge clk);
      chk("orphan_set", 64'(err_orphan), 64'd1);
      chk("orphan_rsp", 64'(rsp_valid), 64'd0);
      repeat (3) cyc();
      @(negedge clk);
      chk("orphan_sticky", 64'(err_orphan), 64'd1);
      cyc();

      // Reset with 5 operations in flight; late products must vanish silently.
      req_valid = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("midrst_grant", 64'(req_ready), 64'd1);
         cyc();
      end
      req_valid = '0; rst = 1'b1;
      @(negedge clk);
      chk("midrst_inflight_pre", 64'(inflight), 64'd5);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_inflight", 64'(inflight), 64'd0);
      chk("midrst_err_clear", 64'(err_orphan), 64'd0);
      for (int c = 0; c < 12; c++) begin
         cyc();
         @(negedge clk);
         chk("midrst_rsp", 64'(rsp_valid), 64'd0);
         chk("midrst_err", 64'(err_orphan), 64'd0);
      end
      cyc();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("midrst_rr_restart", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
